// File: rtl/fe_capture_seq.sv
// fe_capture_seq: capture-enable sequencer for the front-end capture datapath.
//
// After an arm edge the sequencer waits for a trigger edge, counts a programmable
// delay, then holds capture enable high for a programmable window. This repeats for
// a programmable number of segments with a holdoff between them. A FIFO stop ends
// the run early and sets a sticky overflow flag.
//
// Ports:
//   fe_clk            front-end clock, all logic synchronous to it
//   reset_i           synchronous active-high reset
//   I_arm             arm level (already synchronized)
//   I_trig            trigger level (already synchronized)
//   I_delay           trigger-to-window delay in cycles (0 = none)
//   I_window          window length in cycles (0 = open until stop/disarm)
//   I_holdoff         cycles between segments, triggers ignored
//   I_num_segments    segments per run (0 treated as 1)
//   I_fifo_stop       FIFO full / overflow-blocked
//   O_capture_enable  capture qualifier
//   O_armed           high outside IDLE and DONE
//   O_done            high while in DONE
//   O_overflow        sticky, window ended by FIFO stop
//   O_segment_count   completed segments (saturating)
//   O_state           current state encoding, debug only
module fe_capture_seq #(
  parameter int unsigned pDELAY_WIDTH   = 20,
  parameter int unsigned pWINDOW_WIDTH  = 20,
  parameter int unsigned pHOLDOFF_WIDTH = 16,
  parameter int unsigned pSEG_WIDTH     = 8
) (
  input  logic                      fe_clk,
  input  logic                      reset_i,
  input  logic                      I_arm,
  input  logic                      I_trig,
  input  logic [pDELAY_WIDTH-1:0]   I_delay,
  input  logic [pWINDOW_WIDTH-1:0]  I_window,
  input  logic [pHOLDOFF_WIDTH-1:0] I_holdoff,
  input  logic [pSEG_WIDTH-1:0]     I_num_segments,
  input  logic                      I_fifo_stop,
  output logic                      O_capture_enable,
  output logic                      O_armed,
  output logic                      O_done,
  output logic                      O_overflow,
  output logic [pSEG_WIDTH-1:0]     O_segment_count,
  output logic [2:0]                O_state
);

  // One shared counter sized for the widest of delay, window and holdoff.
  localparam int unsigned CntW0 = (pDELAY_WIDTH > pWINDOW_WIDTH) ? pDELAY_WIDTH : pWINDOW_WIDTH;
  localparam int unsigned CntW  = (CntW0 > pHOLDOFF_WIDTH) ? CntW0 : pHOLDOFF_WIDTH;

  localparam logic [CntW-1:0]       CntOne = CntW'(1);
  localparam logic [pSEG_WIDTH-1:0] SegOne = pSEG_WIDTH'(1);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StWaitTrig = 3'd1,
    StDelay    = 3'd2,
    StCapture  = 3'd3,
    StHoldoff  = 3'd4,
    StDone     = 3'd5
  } state_e;

  state_e state_q, state_d;

  logic arm_r, trig_r;
  logic arm_edge, trig_edge;

  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;

  // Run configuration, latched at the arm edge.
  logic [pDELAY_WIDTH-1:0]   delay_q;
  logic [pWINDOW_WIDTH-1:0]  window_q;
  logic [pHOLDOFF_WIDTH-1:0] holdoff_q;
  logic [pSEG_WIDTH-1:0]     nseg_q;
  logic                      cfg_load;

  logic [CntW-1:0] delay_ext, window_ext, holdoff_ext;

  logic [pSEG_WIDTH-1:0] seg_q, seg_d, seg_inc;
  logic                  ovf_q, ovf_d;

  logic cap_en_q, armed_q, done_q;

  assign arm_edge  = I_arm & ~arm_r;
  assign trig_edge = I_trig & ~trig_r;

  assign delay_ext   = CntW'(delay_q);
  assign window_ext  = CntW'(window_q);
  assign holdoff_ext = CntW'(holdoff_q);

  // Both counters saturate instead of wrapping.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CntOne;
  assign seg_inc = (&seg_q) ? seg_q : seg_q + SegOne;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    seg_d    = seg_q;
    ovf_d    = ovf_q;
    cfg_load = 1'b0;

    case (state_q)
      StIdle: begin
        if (arm_edge) begin
          state_d  = StWaitTrig;
          seg_d    = '0;
          ovf_d    = 1'b0;
          cfg_load = 1'b1;
        end
      end

      StWaitTrig: begin
        if (!I_arm) begin
          state_d = StIdle;
        end else if (trig_edge) begin
          cnt_d   = CntOne;
          state_d = (delay_q != '0) ? StDelay : StCapture;
        end
      end

      StDelay: begin
        if (!I_arm) begin
          state_d = StIdle;
        end else if (cnt_q == delay_ext) begin
          state_d = StCapture;
          cnt_d   = CntOne;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      StCapture: begin
        if (!I_arm) begin
          state_d = StIdle;
        end else if (I_fifo_stop) begin
          // FIFO stop wins over a window ending in the same cycle.
          state_d = StDone;
          ovf_d   = 1'b1;
          seg_d   = seg_inc;
        end else if ((window_q != '0) && (cnt_q == window_ext)) begin
          seg_d = seg_inc;
          if (seg_inc >= nseg_q) begin
            state_d = StDone;
          end else if (holdoff_q != '0) begin
            state_d = StHoldoff;
            cnt_d   = CntOne;
          end else begin
            state_d = StWaitTrig;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end

      StHoldoff: begin
        if (!I_arm) begin
          state_d = StIdle;
        end else if (cnt_q == holdoff_ext) begin
          state_d = StWaitTrig;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      StDone: begin
        if (!I_arm) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge fe_clk) begin
    if (reset_i) begin
      state_q   <= StIdle;
      arm_r     <= 1'b0;
      trig_r    <= 1'b0;
      cnt_q     <= '0;
      delay_q   <= '0;
      window_q  <= '0;
      holdoff_q <= '0;
      nseg_q    <= '0;
      seg_q     <= '0;
      ovf_q     <= 1'b0;
      cap_en_q  <= 1'b0;
      armed_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      arm_r   <= I_arm;
      trig_r  <= I_trig;
      cnt_q   <= cnt_d;
      seg_q   <= seg_d;
      ovf_q   <= ovf_d;
      if (cfg_load) begin
        delay_q   <= I_delay;
        window_q  <= I_window;
        holdoff_q <= I_holdoff;
        nseg_q    <= (I_num_segments == '0) ? SegOne : I_num_segments;
      end
      // Flags are decoded from the next state so they line up with state_q.
      cap_en_q <= (state_d == StCapture);
      armed_q  <= (state_d == StWaitTrig) || (state_d == StDelay) ||
                  (state_d == StCapture) || (state_d == StHoldoff);
      done_q   <= (state_d == StDone);
    end
  end

  assign O_capture_enable = cap_en_q;
  assign O_armed          = armed_q;
  assign O_done           = done_q;
  assign O_overflow       = ovf_q;
  assign O_segment_count  = seg_q;
  assign O_state          = state_q;

endmodule

// File: tb/tb_fe_capture_seq.sv
// Directed bench for fe_capture_seq. Inputs change 1 ns after the rising edge and
// outputs are sampled at the same point, so each tick() observes the result of
// exactly one clock edge.
module tb_fe_capture_seq;

  logic        fe_clk;
  logic        reset_i;
  logic        I_arm;
  logic        I_trig;
  logic [19:0] I_delay;
  logic [19:0] I_window;
  logic [15:0] I_holdoff;
  logic [7:0]  I_num_segments;
  logic        I_fifo_stop;
  logic        O_capture_enable;
  logic        O_armed;
  logic        O_done;
  logic        O_overflow;
  logic [7:0]  O_segment_count;
  logic [2:0]  O_state;

  int n_vec = 0;
  int n_err = 0;

  fe_capture_seq dut (
    .fe_clk           (fe_clk),
    .reset_i          (reset_i),
    .I_arm            (I_arm),
    .I_trig           (I_trig),
    .I_delay          (I_delay),
    .I_window         (I_window),
    .I_holdoff        (I_holdoff),
    .I_num_segments   (I_num_segments),
    .I_fifo_stop      (I_fifo_stop),
    .O_capture_enable (O_capture_enable),
    .O_armed          (O_armed),
    .O_done           (O_done),
    .O_overflow       (O_overflow),
    .O_segment_count  (O_segment_count),
    .O_state          (O_state)
  );

  initial fe_clk = 1'b0;
  always #5 fe_clk = ~fe_clk;

  task automatic tick();
    @(posedge fe_clk);
    #1;
  endtask

  task automatic set_cfg(input int d, input int w, input int h, input int n);
    I_delay        = 20'(d);
    I_window       = 20'(w);
    I_holdoff      = 16'(h);
    I_num_segments = 8'(n);
  endtask

  task automatic go_idle();
    I_arm       = 1'b0;
    I_trig      = 1'b0;
    I_fifo_stop = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
    n_vec++; if (O_capture_enable !== 1'b0) begin n_err++; $display("FAIL reset_en got %b want 0", O_capture_enable); end
    n_vec++; if (O_armed !== 1'b0) begin n_err++; $display("FAIL reset_armed got %b want 0", O_armed); end
    n_vec++; if (O_done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", O_done); end
    n_vec++; if (O_overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", O_overflow); end
    n_vec++; if (O_segment_count !== 8'd0) begin n_err++; $display("FAIL reset_seg got %0d want 0", O_segment_count); end
    n_vec++; if (O_state !== 3'd0) begin n_err++; $display("FAIL reset_state got %0d want 0", O_state); end
  endtask

  // D=0 W=8 N=1: enable for 8 ticks starting one tick after the edge, done at 9.
  task automatic test_basic();
    int first_en, n_en, done_at;
    go_idle();
    set_cfg(0, 8, 0, 1);
    I_arm = 1'b1;
    tick();
    n_vec++; if (O_armed !== 1'b1) begin n_err++; $display("FAIL basic_armed got %b want 1", O_armed); end
    n_vec++; if (O_state !== 3'd1) begin n_err++; $display("FAIL basic_state got %0d want 1", O_state); end
    tick();
    tick();
    first_en = -1; n_en = 0; done_at = -1;
    I_trig = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (O_capture_enable) begin
        n_en++;
        if (first_en < 0) first_en = i;
      end
      if (O_done && done_at < 0) done_at = i;
    end
    n_vec++; if (first_en != 1) begin n_err++; $display("FAIL basic_first_en got %0d want 1", first_en); end
    n_vec++; if (n_en != 8) begin n_err++; $display("FAIL basic_en_len got %0d want 8", n_en); end
    n_vec++; if (done_at != 9) begin n_err++; $display("FAIL basic_done_at got %0d want 9", done_at); end
    n_vec++; if (O_segment_count !== 8'd1) begin n_err++; $display("FAIL basic_seg got %0d want 1", O_segment_count); end
    n_vec++; if (O_armed !== 1'b0) begin n_err++; $display("FAIL basic_armed_end got %b want 0", O_armed); end
  endtask

  // D=5 W=4 H=10 N=3, edges at ticks 2, 32, 62 plus a stray edge at 12 in holdoff.
  task automatic test_multi_seg();
    int n_en, n_rise, done_at;
    int rise [3];
    logic prev_en;
    logic [7:0] seg_mid;
    go_idle();
    set_cfg(5, 4, 10, 3);
    I_arm = 1'b1;
    tick();
    n_en = 0; n_rise = 0; done_at = -1; prev_en = 1'b0; seg_mid = 8'hff;
    for (int k = 0; k < 3; k++) rise[k] = -1;
    for (int i = 0; i < 90; i++) begin
      I_trig = (i == 2) || (i == 3) || (i == 12) || (i == 13) ||
               (i == 32) || (i == 33) || (i == 62) || (i == 63);
      tick();
      if (O_capture_enable) n_en++;
      if (O_capture_enable && !prev_en) begin
        if (n_rise < 3) rise[n_rise] = i;
        n_rise++;
      end
      prev_en = O_capture_enable;
      if (O_done && done_at < 0) done_at = i;
      if (i == 20) seg_mid = O_segment_count;
    end
    n_vec++; if (n_en != 12) begin n_err++; $display("FAIL multi_en_total got %0d want 12", n_en); end
    n_vec++; if (n_rise != 3) begin n_err++; $display("FAIL multi_windows got %0d want 3", n_rise); end
    n_vec++; if (rise[0] != 7) begin n_err++; $display("FAIL multi_rise0 got %0d want 7", rise[0]); end
    n_vec++; if (rise[1] != 37) begin n_err++; $display("FAIL multi_rise1 got %0d want 37", rise[1]); end
    n_vec++; if (rise[2] != 67) begin n_err++; $display("FAIL multi_rise2 got %0d want 67", rise[2]); end
    n_vec++; if (done_at != 71) begin n_err++; $display("FAIL multi_done_at got %0d want 71", done_at); end
    n_vec++; if (seg_mid !== 8'd1) begin n_err++; $display("FAIL multi_seg_mid got %0d want 1", seg_mid); end
    n_vec++; if (O_segment_count !== 8'd3) begin n_err++; $display("FAIL multi_seg_end got %0d want 3", O_segment_count); end
    n_vec++; if (O_overflow !== 1'b0) begin n_err++; $display("FAIL multi_ovf got %b want 0", O_overflow); end
  endtask

  // D=0 W=2 H=3 N=2: a rise in the very first WAIT_TRIG cycle after holdoff counts.
  task automatic test_holdoff_edge();
    int n_en, n_rise, done_at;
    int rise [2];
    logic prev_en;
    go_idle();
    set_cfg(0, 2, 3, 2);
    I_arm = 1'b1;
    tick();
    n_en = 0; n_rise = 0; done_at = -1; prev_en = 1'b0;
    rise[0] = -1; rise[1] = -1;
    for (int i = 0; i < 16; i++) begin
      I_trig = (i == 2) || (i == 3) || (i == 8) || (i == 9);
      tick();
      if (O_capture_enable) n_en++;
      if (O_capture_enable && !prev_en) begin
        if (n_rise < 2) rise[n_rise] = i;
        n_rise++;
      end
      prev_en = O_capture_enable;
      if (O_done && done_at < 0) done_at = i;
    end
    n_vec++; if (rise[0] != 2) begin n_err++; $display("FAIL hold_rise0 got %0d want 2", rise[0]); end
    n_vec++; if (rise[1] != 8) begin n_err++; $display("FAIL hold_rise1 got %0d want 8", rise[1]); end
    n_vec++; if (n_en != 4) begin n_err++; $display("FAIL hold_en_total got %0d want 4", n_en); end
    n_vec++; if (done_at != 10) begin n_err++; $display("FAIL hold_done_at got %0d want 10", done_at); end
    n_vec++; if (O_segment_count !== 8'd2) begin n_err++; $display("FAIL hold_seg got %0d want 2", O_segment_count); end
  endtask

  // Trigger already high when armed must fall and rise before a window opens.
  task automatic test_trig_high_at_arm();
    int n_en;
    go_idle();
    set_cfg(0, 3, 0, 1);
    I_trig = 1'b1;
    tick();
    I_arm = 1'b1;
    n_en = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (O_capture_enable) n_en++;
    end
    n_vec++; if (n_en != 0) begin n_err++; $display("FAIL trighigh_no_window got %0d want 0", n_en); end
    n_vec++; if (O_state !== 3'd1) begin n_err++; $display("FAIL trighigh_state got %0d want 1", O_state); end
    I_trig = 1'b0;
    tick();
    I_trig = 1'b1;
    tick();
    n_vec++; if (O_capture_enable !== 1'b1) begin n_err++; $display("FAIL trighigh_open got %b want 1", O_capture_enable); end
    n_en = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (O_capture_enable) n_en++;
    end
    n_vec++; if (n_en != 2) begin n_err++; $display("FAIL trighigh_rest got %0d want 2", n_en); end
    n_vec++; if (O_done !== 1'b1) begin n_err++; $display("FAIL trighigh_done got %b want 1", O_done); end
  endtask

  // W=0: window stays open until the FIFO stops it at window cycle 50.
  task automatic test_fifo_stop();
    int n_en;
    go_idle();
    set_cfg(0, 0, 0, 1);
    I_arm = 1'b1;
    tick();
    I_trig = 1'b1;
    tick();
    n_en = (O_capture_enable === 1'b1) ? 1 : 0;
    for (int i = 0; i < 49; i++) begin
      tick();
      if (O_capture_enable) n_en++;
    end
    n_vec++; if (n_en != 50) begin n_err++; $display("FAIL fifo_open_len got %0d want 50", n_en); end
    I_fifo_stop = 1'b1;
    tick();
    I_fifo_stop = 1'b0;
    n_vec++; if (O_capture_enable !== 1'b0) begin n_err++; $display("FAIL fifo_en got %b want 0", O_capture_enable); end
    n_vec++; if (O_overflow !== 1'b1) begin n_err++; $display("FAIL fifo_ovf got %b want 1", O_overflow); end
    n_vec++; if (O_done !== 1'b1) begin n_err++; $display("FAIL fifo_done got %b want 1", O_done); end
    n_vec++; if (O_segment_count !== 8'd1) begin n_err++; $display("FAIL fifo_seg got %0d want 1", O_segment_count); end
    I_arm = 1'b0;
    I_trig = 1'b0;
    tick();
    tick();
    n_vec++; if (O_overflow !== 1'b1) begin n_err++; $display("FAIL fifo_ovf_sticky got %b want 1", O_overflow); end
    n_vec++; if (O_done !== 1'b0) begin n_err++; $display("FAIL fifo_done_idle got %b want 0", O_done); end
    I_arm = 1'b1;
    tick();
    n_vec++; if (O_overflow !== 1'b0) begin n_err++; $display("FAIL fifo_ovf_rearm got %b want 0", O_overflow); end
    n_vec++; if (O_segment_count !== 8'd0) begin n_err++; $display("FAIL fifo_seg_rearm got %0d want 0", O_segment_count); end
  endtask

  task automatic test_disarm_reset();
    int n_en;
    go_idle();
    set_cfg(20, 4, 0, 1);
    I_arm = 1'b1;
    tick();
    I_trig = 1'b1;
    tick();
    n_vec++; if (O_state !== 3'd2) begin n_err++; $display("FAIL disarm_in_delay got %0d want 2", O_state); end
    tick();
    tick();
    I_arm = 1'b0;
    tick();
    n_vec++; if (O_state !== 3'd0) begin n_err++; $display("FAIL disarm_state got %0d want 0", O_state); end
    n_vec++; if (O_armed !== 1'b0) begin n_err++; $display("FAIL disarm_armed got %b want 0", O_armed); end
    n_vec++; if (O_done !== 1'b0) begin n_err++; $display("FAIL disarm_done got %b want 0", O_done); end
    n_en = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (O_capture_enable) n_en++;
    end
    n_vec++; if (n_en != 0) begin n_err++; $display("FAIL disarm_no_window got %0d want 0", n_en); end
    I_trig = 1'b0;
    set_cfg(0, 10, 0, 1);
    I_arm = 1'b1;
    tick();
    I_trig = 1'b1;
    tick();
    n_vec++; if (O_capture_enable !== 1'b1) begin n_err++; $display("FAIL rearm_open got %b want 1", O_capture_enable); end
    tick();
    tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    I_arm = 1'b0;
    I_trig = 1'b0;
    n_vec++; if (O_capture_enable !== 1'b0) begin n_err++; $display("FAIL midreset_en got %b want 0", O_capture_enable); end
    n_vec++; if (O_armed !== 1'b0) begin n_err++; $display("FAIL midreset_armed got %b want 0", O_armed); end
    n_vec++; if (O_segment_count !== 8'd0) begin n_err++; $display("FAIL midreset_seg got %0d want 0", O_segment_count); end
    n_vec++; if (O_state !== 3'd0) begin n_err++; $display("FAIL midreset_state got %0d want 0", O_state); end
  endtask

  // N=0 runs one segment; raising I_window mid-run leaves the 3-cycle window alone.
  task automatic test_nseg_zero_window_change();
    int n_en;
    go_idle();
    set_cfg(0, 3, 5, 0);
    I_arm = 1'b1;
    tick();
    I_trig = 1'b1;
    tick();
    I_window = 20'd10;
    n_en = (O_capture_enable === 1'b1) ? 1 : 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (O_capture_enable) n_en++;
    end
    n_vec++; if (n_en != 3) begin n_err++; $display("FAIL nseg0_en_len got %0d want 3", n_en); end
    n_vec++; if (O_done !== 1'b1) begin n_err++; $display("FAIL nseg0_done got %b want 1", O_done); end
    n_vec++; if (O_segment_count !== 8'd1) begin n_err++; $display("FAIL nseg0_seg got %0d want 1", O_segment_count); end
    n_vec++; if (O_state !== 3'd5) begin n_err++; $display("FAIL nseg0_state got %0d want 5", O_state); end
  endtask

  initial begin
    reset_i     = 1'b1;
    I_arm       = 1'b0;
    I_trig      = 1'b0;
    I_fifo_stop = 1'b0;
    set_cfg(0, 0, 0, 0);
    test_reset();
    test_basic();
    test_multi_seg();
    test_holdoff_edge();
    test_trig_high_at_arm();
    test_fifo_stop();
    test_disarm_reset();
    test_nseg_zero_window_change();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
